dlx_ifetch: RTL and testbench
=============================

Name: dlx_ifetch

Overview:
- Instruction fetch stage of the DLX datapath, directly upstream of the instruction decoder.
- Owns the PC and issues word requests to instruction memory over a ready-based handshake.
- Registers the returned word into a one-entry instruction slot that drives the decoder's 32-bit INS input.
- Handles pipeline stall and branch/jump redirect, including dropping stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (used only with the optional feature)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of the fetch; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory returns imem_rdata this cycle; request completes
- imem_rdata  in  32  fetched instruction word
- stall  in  1  downstream cannot accept; the instruction slot must hold
- redirect_valid  in  1  taken branch/jump/trap; flush and refetch
- redirect_target  in  32  new PC
- ins  out  32  instruction to decoder (INS[31:0])
- ins_valid  out  1  ins holds a live instruction
- ins_pc  out  32  address of ins
- pc_plus4  out  32  ins_pc+4, link value for JAL/JALR
- fetch_misalign  out  1  one-cycle pulse on a misaligned redirect

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, ins=0, ins_valid=0, ins_pc=0, pc_plus4=0, fetch_misalign=0. imem_req is combinational from state, so it is 1 in the first cycle after reset deasserts.
- States:
  - FETCH: request out, imem_req=1, imem_addr=pc.
  - HOLD: slot full and stalled, imem_req=0.
  - DISCARD: request in flight but stale.
- Slot "free" = ins_valid=0 or stall=0.
- FETCH, imem_ready=1, no redirect:
  - If the slot is free: ins<=imem_rdata, ins_valid<=1, ins_pc<=pc, pc_plus4<=pc+4, pc<=pc+4; stay in FETCH.
  - If the slot is not free: this cannot occur, because FETCH is entered only with the slot free. If stall rises while a request is outstanding, the returned word must still be accepted, so the slot is treated as free; the rule is that stall gates only issue, never completion.
- Issue gating: a new request is issued from FETCH only when the slot is free. After a completion, if stall=1 and ins_valid=1 at that edge, go to HOLD. In HOLD, return to FETCH when stall=0; the held slot is consumed on that same edge.
- Completion latency: the registered output appears the cycle after imem_ready=1. With zero memory wait states and no stall, the stage sustains one instruction per cycle.
- Redirect has priority over stall and completion:
  - ins_valid<=0, ins<=0, pc<=redirect_target.
  - If the state is FETCH with imem_ready=0 (request outstanding), go to DISCARD. imem_addr stays at the old pc until imem_ready. Then drop imem_rdata and return to FETCH at the new pc, which is held in pc.
  - If imem_ready=1 in the same cycle as the redirect, drop the data and go straight to FETCH at the target.
  - From HOLD, go to FETCH.
- A redirect while in DISCARD overwrites pc; stay in DISCARD.
- ins_valid=0 implies ins=32'h0, which decodes as a harmless R-type no-op.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Reset mid-request drops imem_req the next cycle; the memory tolerates an abandoned request.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined: a redirect_target with bits [1:0]≠0 loads pc=TRAP_VECTOR instead of the target. fetch_misalign=1 for exactly the cycle after the redirect. The flush proceeds as for a normal redirect.
- Undefined: redirect_target[1:0] is forced to 2'b00 and fetch_misalign is tied 0.

Test Plan:
- Reset, then memory returns 32'h2001_0005 at 0 wait states -> the cycle after ready shows ins=32'h2001_0005, ins_valid=1, ins_pc=0, pc_plus4=4; the next imem_addr is 4.
- Stall=1 for 3 cycles after ins at pc 8 arrives -> ins, ins_pc=8 and ins_valid are held; imem_req=0 during HOLD; the next fetch at 12 issues when stall falls.
- Memory with 2 wait states, redirect to 32'h40 in the first wait cycle -> imem_addr holds the old pc until ready; that data is never seen on ins; the next request is at 32'h40; ins_valid=0 until then.
- Redirect to 32'h80 with stall=1 and ins_valid=1 -> the next cycle has ins_valid=0, ins=0, imem_addr=32'h80.
- Redirect to 32'hFFFF_FFFC, two fetches -> ins_pc sequence FFFF_FFFC, 0000_0000 with no error.
- With IFETCH_ALIGN_CHECK_EN, redirect to 32'h42 -> fetch_misalign pulses once and the next imem_addr=32'h100. Without the macro -> imem_addr=32'h40 and fetch_misalign stays 0.

Source files
------------

// File: rtl/dlx_ifetch.sv
// DLX instruction fetch stage: owns the PC, fetches over a ready handshake and fills a one-entry slot for the decoder.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned redirects trap to TRAP_VECTOR and pulse fetch_misalign.
module dlx_ifetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] ins_pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        ins_valid_q, ins_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] redirect_pc;
  logic        redirect_misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
  assign redirect_pc         = redirect_misaligned ? TRAP_VECTOR : redirect_target;
`else
  logic unused_align_inputs;
  assign unused_align_inputs = ^{redirect_target[1:0], TRAP_VECTOR};
  assign redirect_misaligned = 1'b0;
  assign redirect_pc         = {redirect_target[31:2], 2'b00};
`endif

  // A stale request keeps presenting its original address until the memory completes it.
  assign imem_req       = (state_q != S_HOLD);
  assign imem_addr      = (state_q == S_DISCARD) ? stale_addr_q : pc_q;
  assign ins            = ins_q;
  assign ins_valid      = ins_valid_q;
  assign ins_pc         = ins_pc_q;
  assign pc_plus4       = pc_plus4_q;
  assign fetch_misalign = misalign_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    ins_d        = ins_q;
    ins_valid_d  = ins_valid_q;
    ins_pc_d     = ins_pc_q;
    pc_plus4_d   = pc_plus4_q;
    misalign_d   = redirect_valid && redirect_misaligned;

    if (redirect_valid) begin
      ins_valid_d = 1'b0;
      ins_d       = 32'h0;
      pc_d        = redirect_pc;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_DISCARD;
            stale_addr_d = pc_q;
          end
        end
        S_HOLD:    state_d = S_FETCH;
        S_DISCARD: state_d = imem_ready ? S_FETCH : S_DISCARD;
        default:   state_d = S_FETCH;
      endcase
    end else begin
      // An unstalled live slot is taken by the decoder on this edge.
      if (ins_valid_q && !stall) begin
        ins_valid_d = 1'b0;
        ins_d       = 32'h0;
      end
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            ins_d       = imem_rdata;
            ins_valid_d = 1'b1;
            ins_pc_d    = pc_q;
            pc_plus4_d  = pc_q + 32'd4;
            pc_d        = pc_q + 32'd4;
            state_d     = stall ? S_HOLD : S_FETCH;
          end
        end
        S_HOLD: begin
          if (!stall) state_d = S_FETCH;
        end
        S_DISCARD: begin
          if (imem_ready) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= 32'h0;
      ins_q        <= 32'h0;
      ins_valid_q  <= 1'b0;
      ins_pc_q     <= 32'h0;
      pc_plus4_q   <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      ins_q        <= ins_d;
      ins_valid_q  <= ins_valid_d;
      ins_pc_q     <= ins_pc_d;
      pc_plus4_q   <= pc_plus4_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_dlx_ifetch.sv
// Bench for dlx_ifetch: directed walk through the fetch scenarios, then randomized traffic checked against
// a transaction-level model (outstanding request, stale flag, slot contents) kept in the bench.
module tb_dlx_ifetch;

  localparam logic [31:0] TRAP_PC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] ins_pc;
  logic [31:0] pc_plus4;
  logic        fetch_misalign;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model of the fetch stage, in terms of requests and the slot rather than FSM states.
  logic        m_req;
  logic [31:0] m_req_addr;
  logic        m_pending;
  logic        m_stale;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ins;
  logic [31:0] m_ins_pc;
  logic [31:0] m_plus4;
  logic        m_misalign;

  dlx_ifetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ins             (ins),
    .ins_valid       (ins_valid),
    .ins_pc          (ins_pc),
    .pc_plus4        (pc_plus4),
    .fetch_misalign  (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2001_0005;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic modelInit();
    m_req      = 1'b1;
    m_req_addr = 32'h0;
    m_pending  = 1'b0;
    m_stale    = 1'b0;
    m_pc       = 32'h0;
    m_valid    = 1'b0;
    m_ins      = 32'h0;
    m_ins_pc   = 32'h0;
    m_plus4    = 32'h0;
    m_misalign = 1'b0;
  endtask

  task automatic compareModel();
    checkOutput("imem_req", {31'h0, imem_req}, {31'h0, m_req});
    if (m_req) checkOutput("imem_addr", imem_addr, m_req_addr);
    checkOutput("ins_valid", {31'h0, ins_valid}, {31'h0, m_valid});
    checkOutput("ins", ins, m_ins);
    if (m_valid) begin
      checkOutput("ins_pc", ins_pc, m_ins_pc);
      checkOutput("pc_plus4", pc_plus4, m_plus4);
    end
    checkOutput("fetch_misalign", {31'h0, fetch_misalign}, {31'h0, m_misalign});
  endtask

  // One clock cycle: compare, drive inputs, advance the model to what the next edge must produce.
  task automatic applyStimulus(input logic stl, input logic rv, input logic [31:0] tgt, input logic rdy);
    logic        complete;
    logic        misal;
    logic [31:0] eff;
    compareModel();
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_ready      = rdy & m_req;
    imem_rdata      = m_req ? memWord(m_req_addr) : $urandom;

    complete = m_req && rdy;
    misal    = rv && (tgt[1:0] != 2'b00);
`ifdef IFETCH_ALIGN_CHECK_EN
    eff        = misal ? TRAP_PC : tgt;
    m_misalign = misal;
`else
    eff        = tgt & 32'hFFFF_FFFC;
    m_misalign = 1'b0;
`endif
    if (rv) begin
      m_valid = 1'b0;
      m_ins   = 32'h0;
      m_pc    = eff;
    end else if (complete && !m_stale) begin
      m_valid  = 1'b1;
      m_ins    = memWord(m_req_addr);
      m_ins_pc = m_req_addr;
      m_plus4  = m_req_addr + 32'd4;
      m_pc     = m_req_addr + 32'd4;
    end else if (m_valid && !stl) begin
      m_valid = 1'b0;
      m_ins   = 32'h0;
    end
    if (complete) begin
      m_pending = 1'b0;
      m_stale   = 1'b0;
    end else if (m_req) begin
      m_pending = 1'b1;
      m_stale   = m_stale | rv;
    end
    m_req = m_pending || !(m_valid && stl);
    if (!m_pending) m_req_addr = m_pc;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_ready      = 1'b0;
    imem_rdata      = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelInit();
  endtask

  initial begin
    logic        r_stall, r_rv, r_rdy;
    logic [31:0] r_tgt;
    doReset();

    checkOutput("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
    checkOutput("rst_ins", ins, 32'h0);
    checkOutput("rst_ins_pc", ins_pc, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h0);
    checkOutput("rst_imem_req", {31'h0, imem_req}, 32'h1);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);

    // First fetch with zero wait states.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("first_ins", ins, 32'h2001_0005);
    checkOutput("first_valid", {31'h0, ins_valid}, 32'h1);
    checkOutput("first_ins_pc", ins_pc, 32'h0);
    checkOutput("first_plus4", pc_plus4, 32'h4);
    checkOutput("first_next_addr", imem_addr, 32'h4);

    // Word at 8 arrives with stall high, held for three stalled edges.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("hold_req", {31'h0, imem_req}, 32'h0);
    checkOutput("hold_ins_pc", ins_pc, 32'h8);
    checkOutput("hold_ins", ins, 32'h2009_0005);
    checkOutput("hold_valid", {31'h0, ins_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("unhold_req", {31'h0, imem_req}, 32'h1);
    checkOutput("unhold_addr", imem_addr, 32'hC);

    // Redirect in the first of two wait cycles.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    checkOutput("discard_addr0", imem_addr, 32'hC);
    checkOutput("discard_valid", {31'h0, ins_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("discard_addr1", imem_addr, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("discard_drop_valid", {31'h0, ins_valid}, 32'h0);
    checkOutput("discard_new_addr", imem_addr, 32'h40);

    // Redirect while the slot is full and stalled.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0);
    checkOutput("flush_valid", {31'h0, ins_valid}, 32'h0);
    checkOutput("flush_ins", ins, 32'h0);
    checkOutput("flush_addr", imem_addr, 32'h80);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_pc0", ins_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_pc1", ins_pc, 32'h0);

    // Misaligned redirect.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef IFETCH_ALIGN_CHECK_EN
    checkOutput("mis_pulse", {31'h0, fetch_misalign}, 32'h1);
    checkOutput("mis_addr", imem_addr, 32'h100);
`else
    checkOutput("mis_pulse", {31'h0, fetch_misalign}, 32'h0);
    checkOutput("mis_addr", imem_addr, 32'h40);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mis_pulse_end", {31'h0, fetch_misalign}, 32'h0);

    // Randomized traffic, with one reset dropped in mid-stream.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      r_stall = ($urandom_range(0, 9) < 3);
      r_rv    = ($urandom_range(0, 19) == 0);
      r_tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) r_tgt[31:4] = 28'hFFF_FFFF;
      r_rdy   = ($urandom_range(0, 1) == 0);
      applyStimulus(r_stall, r_rv, r_tgt, r_rdy);
    end
    compareModel();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
